dart_match_ctrl: RTL and testbench
==================================

DART_MATCH_CTRL -- requirements
Module: dart_match_ctrl

Interface
REQ-001 Parameter: LEGS_TO_WIN, default 3, legs one player must win to take the match (1..7).
REQ-002 Parameter: TIMEOUT_CYC, default 15, maximum cycles in WAIT_DONE before abort (2..255).
REQ-003 Ports (name direction width meaning): clk in 1 clock; reset in 1 reset, synchronous, active-low.
REQ-004 match_start_i in 1 start or restart a match; throw_valid_i in 1 throw offered; throw_x_i in 8 throw x; throw_y_i in 8 throw y.
REQ-005 throw_ready_o out 1 throw accepted when valid and ready are both 1; throw_reject_o out 1 one-cycle pulse when a throw is rejected; timeout_o out 1 one-cycle pulse when a leg is aborted.
REQ-006 dm_reset_o out 1 active-low synchronous reset to the dart machine; dm_come_o out 1 dart strobe; dm_x_o out 8 dart x; dm_y_o out 8 dart y.
REQ-007 dm_p1_done_i, dm_p2_done_i, dm_p1_win_i, dm_p2_win_i, dm_game_set_i: each in 1, driven from the matching dart machine outputs.
REQ-008 leg_p1_o out 3 and leg_p2_o out 3 legs won; match_done_o out 1 match over; match_winner_o out 1 match winner (0 = player 1, 1 = player 2).

Function
REQ-009 FSM states: M_IDLE, DM_RST, DM_INIT, READY, ISSUE, WAIT_DONE, LEG_END, MATCH_END.
REQ-010 M_IDLE: dm_reset_o=0. On match_start_i=1: clear both leg counters, then go to DM_RST.
REQ-011 DM_RST: dm_reset_o=0 for exactly 1 cycle, then go to DM_INIT.
REQ-012 DM_INIT: dm_reset_o=1 for exactly 3 cycles (dart machine START->INITIALIZE->IDLE), then go to READY.
REQ-013 READY: throw_ready_o=1, and only in READY. On valid&&ready: latch x/y, then go to ISSUE.
REQ-014 ISSUE: dm_come_o=1 for exactly 1 cycle, clear the timer, then go to WAIT_DONE.
REQ-015 dm_x_o/dm_y_o come from the latch and stay stable from ISSUE until WAIT_DONE exits; otherwise they hold their last value.
REQ-016 WAIT_DONE, done with game_set: if dm_p1_done_i|dm_p2_done_i=1 and dm_game_set_i=1, go to LEG_END.
REQ-017 WAIT_DONE, done without game_set: if either done input is 1 and dm_game_set_i=0, go to READY.
REQ-018 WAIT_DONE timer: increments every cycle; the done check takes priority over the timer.
REQ-019 WAIT_DONE timeout: if the timer reaches TIMEOUT_CYC with no done, pulse timeout_o 1 cycle and go to DM_RST; leg counters are unchanged.
REQ-020 Nominal latency: done arrives 3 cycles after ISSUE; at most 5 cycles from acceptance to READY.
REQ-021 LEG_END (1 cycle): increment leg_p1_o if dm_p1_win_i=1, else leg_p2_o if dm_p2_win_i=1, else neither; player 1 has priority if both win inputs are 1.
REQ-022 LEG_END exit: if the updated count equals LEGS_TO_WIN, go to MATCH_END; otherwise go to DM_RST.
REQ-023 Leg counters saturate at 7.
REQ-024 MATCH_END: match_done_o=1; match_winner_o is valid; dm_reset_o=1 so final points stay visible.
REQ-025 MATCH_END: on match_start_i=1, clear leg counters and go to DM_RST.
REQ-026 match_start_i is ignored in every state except M_IDLE and MATCH_END.
REQ-027 throw_valid_i is ignored (no pulse, no latch) outside READY.

Reset
REQ-028 While reset=0 on a clock edge: state=M_IDLE, dm_reset_o=0, dm_come_o=0, dm_x_o=dm_y_o=0, leg counters=0, timer=0, all pulses and flags 0.
REQ-029 Reset mid-operation, in any state, aborts immediately; no pending throw is reissued.

Configuration
REQ-030 Macro COORD_CHECK_EN, defined: a throw accepted in READY with x>30 or y>30 is dropped, throw_reject_o pulses 1 cycle, and the FSM stays in READY.
REQ-031 Macro COORD_CHECK_EN, undefined: every accepted throw is forwarded unchanged and throw_reject_o is tied 0.

Verification
REQ-032 Reset then match_start_i -> dm_reset_o low 1 cycle, high 3 cycles, then throw_ready_o=1.
REQ-033 Throw (15,15) into a real dart machine -> dm_come_o 1 cycle; player_1 pts 501->451; FSM back in READY 5 cycles after acceptance.
REQ-034 Done inputs held 0 after ISSUE, TIMEOUT_CYC=15 -> timeout_o pulses after 15 WAIT_DONE cycles, DM_RST follows, legs unchanged.
REQ-035 Stub forcing dm_game_set_i+dm_p2_win_i for 3 legs, LEGS_TO_WIN=3 -> leg_p2_o=3, match_done_o=1, match_winner_o=1.
REQ-036 COORD_CHECK_EN defined, throw (31,0) -> throw_reject_o pulse, no dm_come_o; undefined -> dm_come_o with dm_x_o=31.
REQ-037 reset=0 asserted during WAIT_DONE -> next cycle all outputs at reset values, state M_IDLE.

Source files
------------

// File: rtl/dart_match_ctrl.sv
// dart_match_ctrl: sequences dart machine resets, throws and leg scoring for a best-of match.
// Optional coordinate range check enabled by defining COORD_CHECK_EN.
module dart_match_ctrl #(
  parameter int LEGS_TO_WIN = 3,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       match_start_i,
  input  logic       throw_valid_i,
  input  logic [7:0] throw_x_i,
  input  logic [7:0] throw_y_i,
  output logic       throw_ready_o,
  output logic       throw_reject_o,
  output logic       timeout_o,
  output logic       dm_reset_o,
  output logic       dm_come_o,
  output logic [7:0] dm_x_o,
  output logic [7:0] dm_y_o,
  input  logic       dm_p1_done_i,
  input  logic       dm_p2_done_i,
  input  logic       dm_p1_win_i,
  input  logic       dm_p2_win_i,
  input  logic       dm_game_set_i,
  output logic [2:0] leg_p1_o,
  output logic [2:0] leg_p2_o,
  output logic       match_done_o,
  output logic       match_winner_o
);
  typedef enum logic [2:0] {M_IDLE, DM_RST, DM_INIT, READY, ISSUE, WAIT_DONE, LEG_END, MATCH_END} state_t;
  state_t     r_state, w_next;
  logic [7:0] r_timer, r_x, r_y;
  logic [2:0] r_p1, r_p2, w_p1_inc, w_p2_inc;
  logic       r_timeout, r_reject, r_winner;
  logic       w_done, w_acc, w_bad, w_start, w_expire;
  always_comb begin
    w_done   = dm_p1_done_i | dm_p2_done_i;
    w_acc    = (r_state == READY) && throw_valid_i;
`ifdef COORD_CHECK_EN
    w_bad    = (throw_x_i > 8'd30) || (throw_y_i > 8'd30);
`else
    w_bad    = 1'b0;
`endif
    w_start  = match_start_i && (r_state == M_IDLE || r_state == MATCH_END);
    w_expire = (r_state == WAIT_DONE) && !w_done && (r_timer == 8'(TIMEOUT_CYC - 1));
    w_p1_inc = (r_p1 == 3'd7) ? 3'd7 : r_p1 + 3'd1;
    w_p2_inc = (r_p2 == 3'd7) ? 3'd7 : r_p2 + 3'd1;
    throw_ready_o  = r_state == READY;
    dm_come_o      = r_state == ISSUE;
    dm_reset_o     = !(r_state == M_IDLE || r_state == DM_RST);
    match_done_o   = r_state == MATCH_END;
    match_winner_o = (r_state == MATCH_END) && r_winner;
    w_next = r_state;
    case (r_state)
      M_IDLE:    w_next = match_start_i ? DM_RST : M_IDLE;
      DM_RST:    w_next = DM_INIT;
      DM_INIT:   w_next = (r_timer == 8'd2) ? READY : DM_INIT;
      READY:     w_next = (w_acc && !w_bad) ? ISSUE : READY;
      ISSUE:     w_next = WAIT_DONE;
      WAIT_DONE: w_next = w_done ? (dm_game_set_i ? LEG_END : READY) : (w_expire ? DM_RST : WAIT_DONE);
      LEG_END:   w_next = (dm_p1_win_i ? (w_p1_inc == 3'(LEGS_TO_WIN))
                                       : (dm_p2_win_i && (w_p2_inc == 3'(LEGS_TO_WIN)))) ? MATCH_END : DM_RST;
      MATCH_END: w_next = match_start_i ? DM_RST : MATCH_END;
      default:   w_next = M_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= M_IDLE;
      r_timer   <= 8'd0;
      r_x       <= 8'd0;
      r_y       <= 8'd0;
      r_p1      <= 3'd0;
      r_p2      <= 3'd0;
      r_timeout <= 1'b0;
      r_reject  <= 1'b0;
      r_winner  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_timer   <= (r_state == DM_RST || r_state == ISSUE) ? 8'd0 :
                   (r_state == DM_INIT || r_state == WAIT_DONE) ? r_timer + 8'd1 : r_timer;
      r_timeout <= w_expire;
      r_reject  <= w_acc && w_bad;
      if (w_acc && !w_bad) begin
        r_x <= throw_x_i;
        r_y <= throw_y_i;
      end
      if (w_start) begin
        r_p1 <= 3'd0;
        r_p2 <= 3'd0;
      end else if (r_state == LEG_END) begin
        if (dm_p1_win_i) r_p1 <= w_p1_inc;
        else if (dm_p2_win_i) r_p2 <= w_p2_inc;
        r_winner <= !dm_p1_win_i && dm_p2_win_i;
      end
    end
  end
  assign throw_reject_o = r_reject;
  assign timeout_o      = r_timeout;
  assign dm_x_o         = r_x;
  assign dm_y_o         = r_y;
  assign leg_p1_o       = r_p1;
  assign leg_p2_o       = r_p2;
endmodule

// File: tb/tb_dart_match_ctrl.sv
// tb_dart_match_ctrl: cycle table plus directed sequences for throws, timeout, match scoring and reset.
module tb_dart_match_ctrl;
  logic       clk = 0, reset = 0, st = 0, v = 0;
  logic [7:0] x = 0, y = 0;
  logic       p1d = 0, p2d = 0, p1w = 0, p2w = 0, gs = 0;
  logic       throw_ready_o, throw_reject_o, timeout_o, dm_reset_o, dm_come_o;
  logic [7:0] dm_x_o, dm_y_o;
  logic [2:0] leg_p1_o, leg_p2_o;
  logic       match_done_o, match_winner_o;
  int         n_vec = 0, n_bad = 0;

  dart_match_ctrl #(.LEGS_TO_WIN(3), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .reset(reset), .match_start_i(st), .throw_valid_i(v),
    .throw_x_i(x), .throw_y_i(y), .throw_ready_o(throw_ready_o),
    .throw_reject_o(throw_reject_o), .timeout_o(timeout_o), .dm_reset_o(dm_reset_o),
    .dm_come_o(dm_come_o), .dm_x_o(dm_x_o), .dm_y_o(dm_y_o),
    .dm_p1_done_i(p1d), .dm_p2_done_i(p2d), .dm_p1_win_i(p1w), .dm_p2_win_i(p2w),
    .dm_game_set_i(gs), .leg_p1_o(leg_p1_o), .leg_p2_o(leg_p2_o),
    .match_done_o(match_done_o), .match_winner_o(match_winner_o));

  always #5 clk = ~clk;

  typedef struct {
    logic rn, st, v;
    logic [7:0] x, y;
    logic p1d, p2d, p1w, p2w, gs;
    logic [20:0] ex;
  } vec_t;
  vec_t tbl[16];

  // Packed view: {ready, come, dm_reset, timeout, reject, done, winner, leg_p1, leg_p2, dm_x}
  function automatic logic [20:0] e(input logic rdy, come, dmr, tout, rej, done, win,
                                    input logic [2:0] lp1, lp2, input logic [7:0] xo);
    return {rdy, come, dmr, tout, rej, done, win, lp1, lp2, xo};
  endfunction

  function automatic vec_t mk(input logic rn, s, vv, input logic [7:0] xi, yi,
                              input logic a, b, c, d, g, input logic [20:0] ex);
    vec_t r;
    r.rn = rn; r.st = s; r.v = vv; r.x = xi; r.y = yi;
    r.p1d = a; r.p2d = b; r.p1w = c; r.p2w = d; r.gs = g; r.ex = ex;
    return r;
  endfunction

  function automatic logic [20:0] obs();
    return {throw_ready_o, dm_come_o, dm_reset_o, timeout_o, throw_reject_o,
            match_done_o, match_winner_o, leg_p1_o, leg_p2_o, dm_x_o};
  endfunction

  task automatic chk(input string nm, input logic [20:0] ex);
    n_vec++;
    if (obs() !== ex) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, obs(), ex);
    end
  endtask

  task automatic cmpi(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    reset = 1; st = 0; v = 0; x = 0; y = 0;
    p1d = 0; p2d = 0; p1w = 0; p2w = 0; gs = 0;
  endtask

  task automatic wait_ready(input string nm);
    int k = 0;
    while (!throw_ready_o && k < 20) begin
      tick();
      k++;
    end
    cmpi(nm, int'(throw_ready_o), 1);
  endtask

  task automatic fresh();
    idle_in();
    reset = 0;
    tick();
    reset = 1; st = 1;
    tick();
    st = 0;
    wait_ready("fresh_ready");
  endtask

  task automatic play_leg(input logic a, input logic b);
    wait_ready("leg_ready");
    v = 1; x = 8'd1; y = 8'd1;
    tick();
    v = 0; p2d = 1; gs = 1; p1w = a; p2w = b;
    tick();
    tick();
    tick();
    idle_in();
  endtask

  initial begin
    int k;
    tbl[0]  = mk(0,0,0,  0, 0, 0,0,0,0,0, e(0,0,0,0,0,0,0,0,0,0));
    tbl[1]  = mk(1,0,0,  0, 0, 0,0,0,0,0, e(0,0,0,0,0,0,0,0,0,0));
    tbl[2]  = mk(1,1,0,  0, 0, 0,0,0,0,0, e(0,0,0,0,0,0,0,0,0,0));
    tbl[3]  = mk(1,0,1,  5, 5, 0,0,0,0,0, e(0,0,1,0,0,0,0,0,0,0));
    tbl[4]  = mk(1,0,1,  5, 5, 0,0,0,0,0, e(0,0,1,0,0,0,0,0,0,0));
    tbl[5]  = mk(1,0,1,  5, 5, 0,0,0,0,0, e(0,0,1,0,0,0,0,0,0,0));
    tbl[6]  = mk(1,0,1,  5, 5, 0,0,0,0,0, e(1,0,1,0,0,0,0,0,0,0));
    tbl[7]  = mk(1,0,1, 15,15, 0,0,0,0,0, e(0,1,1,0,0,0,0,0,0,15));
    tbl[8]  = mk(1,0,0,  0, 0, 0,0,0,0,0, e(0,0,1,0,0,0,0,0,0,15));
    tbl[9]  = mk(1,0,0,  0, 0, 0,0,0,0,0, e(0,0,1,0,0,0,0,0,0,15));
    tbl[10] = mk(1,0,0,  0, 0, 1,0,0,0,0, e(1,0,1,0,0,0,0,0,0,15));
    tbl[11] = mk(1,0,1, 20, 7, 0,0,0,0,0, e(0,1,1,0,0,0,0,0,0,20));
    tbl[12] = mk(1,0,0,  0, 0, 0,0,0,0,0, e(0,0,1,0,0,0,0,0,0,20));
    tbl[13] = mk(1,0,0,  0, 0, 0,1,0,1,1, e(0,0,1,0,0,0,0,0,0,20));
    tbl[14] = mk(1,0,0,  0, 0, 0,1,0,1,1, e(0,0,0,0,0,0,0,0,1,20));
    tbl[15] = mk(1,1,0,  0, 0, 0,0,0,0,0, e(0,0,1,0,0,0,0,0,1,20));
    for (int i = 0; i < 16; i++) begin
      reset = tbl[i].rn; st = tbl[i].st; v = tbl[i].v; x = tbl[i].x; y = tbl[i].y;
      p1d = tbl[i].p1d; p2d = tbl[i].p2d; p1w = tbl[i].p1w; p2w = tbl[i].p2w; gs = tbl[i].gs;
      tick();
      chk($sformatf("table_%0d", i), tbl[i].ex);
    end

    fresh();
    v = 1; x = 8'd31; y = 8'd0;
    tick();
    v = 0;
`ifdef COORD_CHECK_EN
    chk("coord_reject31", e(1,0,1,0,1,0,0,0,0,0));
    tick();
    chk("coord_reject_end", e(1,0,1,0,0,0,0,0,0,0));
`else
    chk("coord_forward31", e(0,1,1,0,0,0,0,0,0,31));
    tick();
    chk("coord_forward_wait", e(0,0,1,0,0,0,0,0,0,31));
`endif
    fresh();
    v = 1; x = 8'd30; y = 8'd30;
    tick();
    v = 0;
    chk("coord_edge30", e(0,1,1,0,0,0,0,0,0,30));

    fresh();
    play_leg(0, 1);
    wait_ready("timeout_ready");
    v = 1; x = 8'd9; y = 8'd9;
    tick();
    v = 0;
    k = 1;
    while (!timeout_o && k < 40) begin
      tick();
      k++;
    end
    cmpi("timeout_edges", k, 17);
    chk("timeout_pulse", e(0,0,0,1,0,0,0,0,1,9));
    tick();
    chk("timeout_after", e(0,0,1,0,0,0,0,0,1,9));

    fresh();
    play_leg(1, 1);
    chk("leg_p1_priority", e(0,0,0,0,0,0,0,1,0,1));
    play_leg(0, 0);
    chk("leg_no_winner", e(0,0,0,0,0,0,0,1,0,1));
    play_leg(0, 1);
    play_leg(0, 1);
    chk("leg_p2_two", e(0,0,0,0,0,0,0,1,2,1));
    play_leg(0, 1);
    chk("match_end", e(0,0,1,0,0,1,1,1,3,1));
    tick();
    chk("match_hold", e(0,0,1,0,0,1,1,1,3,1));
    st = 1;
    tick();
    st = 0;
    chk("match_restart", e(0,0,0,0,0,0,0,0,0,1));

    fresh();
    play_leg(0, 1);
    wait_ready("rst_ready");
    v = 1; x = 8'd7; y = 8'd7;
    tick();
    v = 0;
    tick();
    reset = 0;
    tick();
    chk("reset_mid_wait", e(0,0,0,0,0,0,0,0,0,0));
    reset = 1;
    tick();
    chk("reset_idle_1", e(0,0,0,0,0,0,0,0,0,0));
    tick();
    chk("reset_idle_2", e(0,0,0,0,0,0,0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
